// File: rtl/pixel_sched_pkg.sv
// pixel_sched_pkg: scheduler state encoding, default frame/window geometry and owner pick
package pixel_sched_pkg;
  typedef enum logic [1:0] {IDLE, ARB, STREAM, DONE} sched_state_e;
  localparam int SRC_COLS_DEF = 1201;
  localparam int SRC_ROWS_DEF = 1201;
  localparam int WIN_COLS_DEF = 800;
  localparam int WIN_ROWS_DEF = 600;
  localparam int CW_DEF       = 13;
  function automatic logic pick_owner(input logic [1:0] req, input logic last_owner);
    return req[~last_owner] ? ~last_owner : last_owner;
  endfunction
endpackage

// File: rtl/pixel_out_reg.sv
// pixel_out_reg: one-entry valid/ready output register with synchronous flush
module pixel_out_reg (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       free_o
);
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  // flush drops the held beat; a load only arrives when the slot is free
  always_comb begin
    valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : ready_i ? 1'b0 : valid_q;
    data_d  = flush_i ? 8'd0 : load_i ? data_i : ready_i ? 8'd0 : data_q;
  end
  // register the slot, data reads zero whenever it is empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/pixel_frame_scheduler.sv
// pixel_frame_scheduler: frame-granular round-robin share of the pixel path, window forwarding
module pixel_frame_scheduler
  import pixel_sched_pkg::*;
#(
  parameter int SRC_COLS = SRC_COLS_DEF,
  parameter int SRC_ROWS = SRC_ROWS_DEF,
  parameter int WIN_COLS = WIN_COLS_DEF,
  parameter int WIN_ROWS = WIN_ROWS_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    req_i,
  output logic [1:0]    grant_o,
  input  logic          src0_valid_i,
  input  logic [7:0]    src0_pixel_i,
  output logic          src0_ready_o,
  input  logic          src1_valid_i,
  input  logic [7:0]    src1_pixel_i,
  output logic          src1_ready_o,
  output logic          dn_valid_o,
  output logic [7:0]    dn_pixel_o,
  input  logic          dn_ready_i,
  input  logic          abort_i,
  output logic          frame_start_o,
  output logic          frame_done_o,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o
);
  localparam logic [CW-1:0] COL_LAST = CW'(SRC_COLS - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(SRC_ROWS - 1);
  localparam logic [CW-1:0] WIN_C    = CW'(WIN_COLS);
  localparam logic [CW-1:0] WIN_R    = CW'(WIN_ROWS);
  sched_state_e  state_q;
  logic [1:0]    grant_q;
  logic          last_q, fs_q, fd_q;
  logic [CW-1:0] row_q, col_q;
  logic          in_win, slot_free, own_ready, accept, last_beat, nxt;
  logic [7:0]    own_pixel;
  assign in_win       = row_q < WIN_R && col_q < WIN_C;
  assign own_ready    = state_q == STREAM && (in_win ? slot_free : 1'b1);
  assign src0_ready_o = own_ready && grant_q[0];
  assign src1_ready_o = own_ready && grant_q[1];
  assign accept       = (src0_valid_i && src0_ready_o) || (src1_valid_i && src1_ready_o);
  assign own_pixel    = grant_q[1] ? src1_pixel_i : src0_pixel_i;
  assign last_beat    = row_q == ROW_LAST && col_q == COL_LAST;
  assign nxt          = pick_owner(req_i, last_q);
  assign grant_o       = grant_q;
  assign frame_start_o = fs_q;
  assign frame_done_o  = fd_q;
  assign row_o         = row_q;
  assign col_o         = col_q;
  pixel_out_reg u_out (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .load_i  (accept && in_win),
    .data_i  (own_pixel),
    .ready_i (dn_ready_i),
    .valid_o (dn_valid_o),
    .data_o  (dn_pixel_o),
    .free_o  (slot_free)
  );
  // frame FSM: arbitration at boundaries, raster position, registered grant and pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (abort_i) begin
      state_q <= ARB;
      grant_q <= 2'b00;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      fs_q <= 1'b0;
      fd_q <= 1'b0;
      case (state_q)
        IDLE: state_q <= req_i != 2'b00 ? ARB : IDLE;
        ARB: begin
          if (req_i == 2'b00) state_q <= IDLE;
          else begin
            state_q <= STREAM;
            grant_q <= {nxt, ~nxt};
            last_q  <= nxt;
            fs_q    <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        STREAM: begin
          if (accept && last_beat) begin
            state_q <= DONE;
            grant_q <= 2'b00;
            fd_q    <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
          end else if (accept) begin
            col_q <= col_q == COL_LAST ? '0 : col_q + 1'b1;
            row_q <= col_q == COL_LAST ? row_q + 1'b1 : row_q;
          end
        end
        DONE: state_q <= ARB;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// tb_pixel_frame_scheduler: directed checks of arbitration, windowing, backpressure and abort
module tb_pixel_frame_scheduler;
  localparam int SC = 6, SR = 5, WC = 4, WR = 3, CWB = 4, TOT = SC * SR;
  logic clk = 0, rst = 0;
  logic [1:0] req_i = 0, grant_o;
  logic src0_valid_i = 0, src1_valid_i = 0, src0_ready_o, src1_ready_o;
  logic [7:0] src0_pixel_i = 0, src1_pixel_i = 0, dn_pixel_o;
  logic dn_valid_o, dn_ready_i = 1, abort_i = 0, frame_start_o, frame_done_o;
  logic [CWB-1:0] row_o, col_o;
  always #5 clk = ~clk;
  pixel_frame_scheduler #(.SRC_COLS(SC), .SRC_ROWS(SR), .WIN_COLS(WC), .WIN_ROWS(WR), .CW(CWB)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .grant_o(grant_o),
    .src0_valid_i(src0_valid_i), .src0_pixel_i(src0_pixel_i), .src0_ready_o(src0_ready_o),
    .src1_valid_i(src1_valid_i), .src1_pixel_i(src1_pixel_i), .src1_ready_o(src1_ready_o),
    .dn_valid_o(dn_valid_o), .dn_pixel_o(dn_pixel_o), .dn_ready_i(dn_ready_i),
    .abort_i(abort_i), .frame_start_o(frame_start_o), .frame_done_o(frame_done_o),
    .row_o(row_o), .col_o(col_o)
  );
  int n_chk = 0, n_err = 0;
  int pos[2] = '{0, 0};
  logic [1:0] fcnt[2] = '{2'd0, 2'd0};
  logic [7:0] expq[$];
  int n_dn = 0, n_acc = 0, n_fs = 0, n_fd = 0, dn0 = 0, acc0 = 0, fs0 = 0, fd_b, fs_b;
  logic [1:0] fs_grant = 0;
  bit prev_hold = 0, tog = 0, rnd = 0;
  logic [7:0] prev_pix = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] enc(input int s);
    return {s[0], fcnt[s], 5'(pos[s])};
  endfunction
  task automatic model_reset();
    pos = '{0, 0};
    expq.delete();
    prev_hold = 0;
  endtask
  task automatic mon();
    logic v, r;
    if (frame_start_o) begin
      fs0 = n_fs; n_fs++; fs_grant = grant_o; dn0 = n_dn; acc0 = n_acc;
    end
    if (prev_hold) begin
      check("dn_hold_v", dn_valid_o, 1);
      check("dn_hold_pix", dn_pixel_o, prev_pix);
    end
    if (!dn_valid_o) check("dn_zero", dn_pixel_o, 0);
    if (dn_valid_o && dn_ready_i) begin
      if (expq.size() == 0) check("dn_extra", expq.size(), 1);
      else check("dn_pix", dn_pixel_o, expq.pop_front());
      n_dn++;
    end
    prev_hold = dn_valid_o && !dn_ready_i;
    prev_pix = dn_pixel_o;
    check("rdy_excl", src0_ready_o & src1_ready_o, 0);
    for (int s = 0; s < 2; s++) begin
      v = s == 1 ? src1_valid_i : src0_valid_i;
      r = s == 1 ? src1_ready_o : src0_ready_o;
      if (v && r) begin
        check("row", row_o, pos[s] / SC);
        check("col", col_o, pos[s] % SC);
        if (pos[s] / SC < WR && pos[s] % SC < WC) expq.push_back(enc(s));
        n_acc++;
        pos[s]++;
        if (pos[s] == TOT) begin pos[s] = 0; fcnt[s]++; end
      end
    end
    if (frame_done_o) begin
      n_fd++;
      check("frm_dn", n_dn - dn0, WR * WC);
      check("frm_acc", n_acc - acc0, TOT);
      check("frm_fs", n_fs - fs0, 1);
      check("q_empty", expq.size(), 0);
    end
    if (abort_i) model_reset();
  endtask
  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rnd) begin
      src0_valid_i = 1'($urandom_range(0, 1));
      src1_valid_i = 1'($urandom_range(0, 1));
    end
    if (tog) dn_ready_i = !dn_ready_i;
    src0_pixel_i = enc(0);
    src1_pixel_i = enc(1);
  endtask
  task automatic wait_fs(input int lim);
    int n;
    n = n_fs;
    for (int i = 0; i < lim && n_fs == n; i++) cyc();
    check("fs_seen", n_fs - n, 1);
  endtask
  task automatic wait_fd(input int lim);
    int n;
    n = n_fd;
    for (int i = 0; i < lim && n_fd == n; i++) cyc();
    check("fd_seen", n_fd - n, 1);
  endtask
  task automatic run_frame(input logic [1:0] g);
    wait_fs(20);
    check("grant", fs_grant, g);
    wait_fd(400);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #2 rst = 1;
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_dnv", dn_valid_o, 0);
    check("rst_dnp", dn_pixel_o, 0);
    check("rst_row", row_o, 0);
    check("rst_col", col_o, 0);
    check("rst_fs", frame_start_o, 0);
    check("rst_fd", frame_done_o, 0);
    check("rst_rdy0", src0_ready_o, 0);
    repeat (2) cyc();
    rst = 0; req_i = 2'b11; src0_valid_i = 1; src1_valid_i = 1;
    wait_fs(20);
    check("t1_first", fs_grant, 2'b01);
    repeat (8) cyc();
    rst = 1;
    #1;
    check("t1_grant", grant_o, 0);
    check("t1_dnv", dn_valid_o, 0);
    check("t1_row", row_o, 0);
    check("t1_col", col_o, 0);
    model_reset();
    repeat (2) cyc();
    rst = 0;
    run_frame(2'b01);
    run_frame(2'b10);
    run_frame(2'b01);
    tog = 1; rnd = 1;
    run_frame(2'b10);
    tog = 0; rnd = 0; dn_ready_i = 1; src0_valid_i = 1; src1_valid_i = 1;
    wait_fs(20);
    check("t5_grant", fs_grant, 2'b01);
    for (int i = 0; i < 200 && pos[0] != TOT - 1; i++) cyc();
    check("t5_reach", pos[0], TOT - 1);
    fd_b = n_fd;
    abort_i = 1;
    cyc();
    abort_i = 0; req_i = 2'b10;
    check("ab_grant0", grant_o, 0);
    check("ab_dnv", dn_valid_o, 0);
    check("ab_row", row_o, 0);
    check("ab_col", col_o, 0);
    check("ab_fd", frame_done_o, 0);
    check("ab_fs0", frame_start_o, 0);
    cyc();
    check("ab_fs", frame_start_o, 1);
    check("ab_next", grant_o, 2'b10);
    check("ab_nofd", n_fd, fd_b);
    repeat (5) cyc();
    req_i = 2'b00;
    wait_fd(400);
    fs_b = n_fs;
    repeat (5) cyc();
    check("idle_grant", grant_o, 0);
    check("idle_fs", n_fs, fs_b);
    check("idle_rdy1", src1_ready_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
